fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one FIFO write port between N_REQ producers in the face-filter pipeline. Each producer offers words with a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST words and drives the FIFO's write-enable and write-data. It never writes while the FIFO reports full.

---
 rtl/fifo_wr_arbiter_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_if.sv | 34 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 94 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   function automatic int unsigned id_w(input int unsigned n_req);
      return (n_req <= 2) ? 1 : $clog2(n_req);
   endfunction

   function automatic int unsigned beat_w(input int unsigned burst);
      return $clog2(burst) + 1;
   endfunction

   localparam int unsigned BURST_DFLT  = 4;
   localparam int unsigned BEAT_W_DFLT = beat_w(BURST_DFLT);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake + FIFO write port bundle. Optional FIFO_ARB_TAG_EN widens
// fifo_wdata by the source ID.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_WIDTH = 8
) ();
   localparam int unsigned ID_W = id_w(N_REQ);
`ifdef FIFO_ARB_TAG_EN
   localparam int unsigned WD_W = DATA_WIDTH + ID_W;
`else
   localparam int unsigned WD_W = DATA_WIDTH;
`endif

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ*DATA_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]            req_ready;
   logic                        fifo_full;
   logic                        fifo_wren;
   logic [WD_W-1:0]             fifo_wdata;
   logic [ID_W-1:0]             grant_id;
   logic                        busy;

   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_wren, fifo_wdata, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_wren, fifo_wdata, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority finder: first set bit of req at or after base,
// wrapping modulo N_REQ (N_REQ need not be a power of two).
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  base,
   output logic             found,
   output logic [ID_W-1:0]  idx
);
   int unsigned     c;
   logic [ID_W-1:0] c_id;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      c     = 0;
      c_id  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         c = 32'(base) + i;
         if (c >= N_REQ) c = c - N_REQ;
         c_id = ID_W'(c);
         if (!found && req[c_id]) begin
            found = 1'b1;
            idx   = c_id;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers in
// bursts of up to BURST words. FIFO_ARB_TAG_EN prepends the owner ID to fifo_wdata.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST      = BURST_DFLT
) (
   input logic               clk,
   input logic               rst_n,
   fifo_wr_arbiter_if.master bus
);
   localparam int unsigned       ID_W      = id_w(N_REQ);
   localparam int unsigned       BEAT_W    = beat_w(BURST);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
   localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);

   arb_state_e              state, state_nx;
   logic [ID_W-1:0]         owner, owner_nx, rr_ptr, rr_nx;
   logic [ID_W-1:0]         owner_inc, pick_base, pick_idx;
   logic [BEAT_W-1:0]       beat_cnt, beat_nx;
   logic                    pick_found, own_valid, xfer, rel;
   logic [DATA_WIDTH-1:0]   own_data;

   assign owner_inc = (owner == LAST_ID) ? '0 : owner + 1'b1;
   // One finder serves both the IDLE pick and the same-cycle handover search.
   assign pick_base = (state == GRANT) ? owner_inc : rr_ptr;

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req   (bus.req_valid),
      .base  (pick_base),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign own_valid = bus.req_valid[owner];
   assign own_data  = bus.req_data[32'(owner) * DATA_WIDTH +: DATA_WIDTH];
   assign xfer      = (state == GRANT) && own_valid && !bus.fifo_full;
   assign rel       = (state == GRANT) && (!own_valid || (xfer && beat_cnt == LAST_BEAT));

   assign bus.grant_id = owner;
   assign bus.busy     = (state == GRANT);

   always_comb begin
      state_nx       = state;
      owner_nx       = owner;
      beat_nx        = beat_cnt;
      rr_nx          = rr_ptr;
      bus.req_ready  = '0;
      bus.fifo_wren  = 1'b0;
      bus.fifo_wdata = '0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nx = GRANT;
               owner_nx = pick_idx;
               beat_nx  = '0;
            end
         end
         GRANT: begin
            bus.req_ready[owner] = !bus.fifo_full;
            bus.fifo_wren        = xfer;
`ifdef FIFO_ARB_TAG_EN
            bus.fifo_wdata = {owner, own_data};
`else
            bus.fifo_wdata = own_data;
`endif
            if (xfer) beat_nx = beat_cnt + 1'b1;
            if (rel) begin
               rr_nx   = owner_inc;
               beat_nx = '0;
               if (pick_found) owner_nx = pick_idx;
               else            state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nx;
         owner    <= owner_nx;
         rr_ptr   <= rr_nx;
         beat_cnt <= beat_nx;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter (N_REQ=4 and N_REQ=3 instances);
// expected fifo_wdata follows FIFO_ARB_TAG_EN when defined.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.N_REQ(4), .DATA_WIDTH(8)) bus4 ();
   fifo_wr_arbiter_if #(.N_REQ(3), .DATA_WIDTH(8)) bus3 ();

   fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .BURST(4)) dut (
      .clk (clk), .rst_n (rst_n), .bus (bus4)
   );
   fifo_wr_arbiter #(.N_REQ(3), .DATA_WIDTH(8), .BURST(2)) dut3 (
      .clk (clk), .rst_n (rst_n), .bus (bus3)
   );

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic        full;
      logic [3:0]  ready;
      logic        wren;
      logic [7:0]  wd;
      logic [1:0]  gid;
      logic        busy;
   } vec_t;

   vec_t tbl[$];
   int   nvec = 0;
   int   nerr = 0;

   function automatic vec_t mk(input logic [3:0] va, input logic [7:0] d0, input logic fu,
                               input logic [3:0] rd, input logic we, input logic [7:0] wd,
                               input logic [1:0] g, input logic bz);
      mk = '{va, {8'hD3, 8'hC2, 8'hB1, d0}, fu, rd, we, wd, g, bz};
   endfunction

   function automatic void add(input logic [3:0] va, input logic [7:0] d0, input logic fu,
                               input logic [3:0] rd, input logic we, input logic [7:0] wd,
                               input logic [1:0] g, input logic bz);
      tbl.push_back(mk(va, d0, fu, rd, we, wd, g, bz));
   endfunction

   function automatic logic [31:0] exp_wd(input logic bz, input logic [1:0] g, input logic [7:0] d);
      if (!bz) return 32'd0;
`ifdef FIFO_ARB_TAG_EN
      return {22'd0, g, d};
`else
      return {24'd0, d};
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      bus4.req_valid = v.valid;
      bus4.req_data  = v.data;
      bus4.fifo_full = v.full;
      #2;
      chk({nm, ".ready"}, 32'(bus4.req_ready),  32'(v.ready));
      chk({nm, ".wren"},  32'(bus4.fifo_wren),  32'(v.wren));
      chk({nm, ".wdata"}, 32'(bus4.fifo_wdata), exp_wd(v.busy, v.gid, v.wd));
      chk({nm, ".gid"},   32'(bus4.grant_id),   32'(v.gid));
      chk({nm, ".busy"},  32'(bus4.busy),       32'(v.busy));
      @(posedge clk); #1;
   endtask

   task automatic apply3(input logic [2:0] va, input logic [2:0] rd, input logic we,
                         input logic [1:0] g, input logic bz, input string nm);
      bus3.req_valid = va;
      #2;
      chk({nm, ".ready"}, 32'(bus3.req_ready),  32'(rd));
      chk({nm, ".wren"},  32'(bus3.fifo_wren),  32'(we));
      chk({nm, ".wdata"}, 32'(bus3.fifo_wdata), exp_wd(bz, g, 8'h60 + 8'(g)));
      chk({nm, ".gid"},   32'(bus3.grant_id),   32'(g));
      chk({nm, ".busy"},  32'(bus3.busy),       32'(bz));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] pw [4];
      vec_t       v;
      pw = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

      // Single requester 0, words 0x11..0x16, then drop.
      add(4'b0000, 8'h11, 0, 4'b0000, 0, 8'h00, 0, 0);
      add(4'b0001, 8'h11, 0, 4'b0000, 0, 8'h00, 0, 0);
      for (int i = 0; i < 6; i++)
         add(4'b0001, 8'h11 + 8'(i), 0, 4'b0001, 1, 8'h11 + 8'(i), 0, 1);
      add(4'b0000, 8'h16, 0, 4'b0001, 0, 8'h16, 0, 1);
      add(4'b0000, 8'h16, 0, 4'b0000, 0, 8'h00, 0, 0);
      // All four valid: rr_ptr=1 so rotation is 1,2,3,0 with no bubbles.
      add(4'b1111, 8'hA0, 0, 4'b0000, 0, 8'h00, 0, 0);
      for (int k = 0; k < 4; k++) begin
         int o;
         o = (k + 1) % 4;
         for (int b = 0; b < 4; b++)
            add(4'b1111, 8'hA0, 0, 4'(1 << o), 1, pw[o], 2'(o), 1);
      end
      add(4'b0000, 8'hA0, 0, 4'b0010, 0, 8'hB1, 1, 1);
      // Producer 2 burst with a 3-cycle full stall after the first beat.
      add(4'b0100, 8'hA0, 0, 4'b0000, 0, 8'h00, 1, 0);
      add(4'b0100, 8'hA0, 0, 4'b0100, 1, 8'hC2, 2, 1);
      for (int i = 0; i < 3; i++) add(4'b0100, 8'hA0, 1, 4'b0000, 0, 8'hC2, 2, 1);
      for (int i = 0; i < 3; i++) add(4'b0100, 8'hA0, 0, 4'b0100, 1, 8'hC2, 2, 1);
      add(4'b0000, 8'hA0, 0, 4'b0100, 0, 8'hC2, 2, 1);

      bus4.req_valid = 4'hF; bus4.req_data = '0; bus4.fifo_full = 1'b0;
      bus3.req_valid = '0;   bus3.req_data = 24'h626160; bus3.fifo_full = 1'b0;
      #2;
      chk("rst.ready", 32'(bus4.req_ready), 32'd0);
      chk("rst.wren",  32'(bus4.fifo_wren), 32'd0);
      chk("rst.busy",  32'(bus4.busy),      32'd0);
      @(posedge clk); @(posedge clk); #1;
      bus4.req_valid = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

      // Producer 1 drops after two beats while producer 3 waits.
      apply(mk(4'b1000, 8'hA0, 0, 4'b0000, 0, 8'h00, 2, 0), "d0");
      apply(mk(4'b0000, 8'hA0, 0, 4'b1000, 0, 8'hD3, 3, 1), "d1");
      apply(mk(4'b1010, 8'hA0, 0, 4'b0000, 0, 8'h00, 3, 0), "d2");
      apply(mk(4'b1010, 8'hA0, 0, 4'b0010, 1, 8'hB1, 1, 1), "d3");
      apply(mk(4'b1010, 8'hA0, 0, 4'b0010, 1, 8'hB1, 1, 1), "d4");
      apply(mk(4'b1000, 8'hA0, 0, 4'b0010, 0, 8'hB1, 1, 1), "d5");
      chk("d.rr_ptr", 32'(dut.rr_ptr), 32'd2);
      apply(mk(4'b1000, 8'hA0, 0, 4'b1000, 1, 8'hD3, 3, 1), "d6");
      bus4.req_valid = '0;

      // N_REQ=3, BURST=2: rr_ptr wrap 2->0, then reset mid-burst.
      apply3(3'b010, 3'b000, 0, 0, 0, "n0");
      apply3(3'b000, 3'b010, 0, 1, 1, "n1");
      chk("n.rr_a", 32'(dut3.rr_ptr), 32'd2);
      apply3(3'b100, 3'b000, 0, 1, 0, "n2");
      apply3(3'b010, 3'b100, 0, 2, 1, "n3");
      chk("n.rr_wrap", 32'(dut3.rr_ptr), 32'd0);
      apply3(3'b010, 3'b010, 1, 1, 1, "n4");
      apply3(3'b010, 3'b010, 1, 1, 1, "n5");
      chk("n.rr_b", 32'(dut3.rr_ptr), 32'd2);
      #2;
      chk("n.pre_rst_wren", 32'(bus3.fifo_wren), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("n.rst_wren",  32'(bus3.fifo_wren),  32'd0);
      chk("n.rst_ready", 32'(bus3.req_ready),  32'd0);
      chk("n.rst_busy",  32'(bus3.busy),       32'd0);
      chk("n.rst_gid",   32'(bus3.grant_id),   32'd0);
      chk("n.rst_wdata", 32'(bus3.fifo_wdata), 32'd0);
      chk("n.rst_rr",    32'(dut3.rr_ptr),     32'd0);
      chk("n.rst_state", 32'(dut3.state),      32'(IDLE));
      @(posedge clk); #1;
      chk("n.rst_hold_wren", 32'(bus3.fifo_wren), 32'd0);
      bus3.req_valid = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Producer 2 writes 0xA5; tagged build carries ID 2 in the MSBs.
      v = mk(4'b0100, 8'hA0, 0, 4'b0000, 0, 8'h00, 0, 0);
      v.data[23:16] = 8'hA5;
      apply(v, "t0");
      bus4.req_valid = 4'b0100;
      #2;
`ifdef FIFO_ARB_TAG_EN
      chk("tag.wdata", 32'(bus4.fifo_wdata), 32'h2A5);
`else
      chk("tag.wdata", 32'(bus4.fifo_wdata), 32'hA5);
`endif
      chk("tag.wren", 32'(bus4.fifo_wren), 32'd1);
      @(posedge clk); #1;
      bus4.req_valid = '0;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
